uart_cmd_rcv: RTL and testbench

Serial command receiver and power-up authorizer for the Segway top level. Deserializes 8N1 UART frames arriving from the BLE module on `RX`, presents each valid byte with a ready/clear handshake, and tracks the 'G' (go) / 'S' (stop) command protocol to drive `pwr_up`. It is the receiving end of the link driven by `UART_tx`.

---
 rtl/uart_cmd_pkg.sv | 8 +
 rtl/uart_cmd_auth.sv | 37 +++
 rtl/uart_cmd_rcv.sv | 111 +++++++++++
 tb/tb_uart_cmd_rcv.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: shared state encodings, command bytes and default baud divisor
package uart_cmd_pkg;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;
  typedef enum logic [1:0] {AUTH_OFF, AUTH_PWR, AUTH_PEND} auth_state_t;
  localparam logic [7:0] CMD_GO = 8'h47;
  localparam logic [7:0] CMD_STOP = 8'h53;
  localparam int BAUD_DIV_DEF = 2604;
endpackage

// File: rtl/uart_cmd_auth.sv
// uart_cmd_auth: G/S command tracker producing the registered pwr_up enable
module uart_cmd_auth
  import uart_cmd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_vld,
  input  logic [7:0] rx_data,
  input  logic       rider_off,
  output logic       pwr_up
);
  auth_state_t state_q, state_d;
  logic pwr_up_q;
  logic go, stop;
  assign go = rx_vld && rx_data == CMD_GO;
  assign stop = rx_vld && rx_data == CMD_STOP;
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      AUTH_OFF:  state_d = go ? AUTH_PWR : AUTH_OFF;
      AUTH_PWR:  state_d = stop ? (rider_off ? AUTH_OFF : AUTH_PEND) : AUTH_PWR;
      AUTH_PEND: state_d = go ? AUTH_PWR : rider_off ? AUTH_OFF : AUTH_PEND;
      default:   state_d = AUTH_OFF;
    endcase
  end
  // pwr_up is taken from the next state so it follows rx_vld by exactly one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= AUTH_OFF;
      pwr_up_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pwr_up_q <= state_d != AUTH_OFF;
    end
  end
  assign pwr_up = pwr_up_q;
endmodule

// File: rtl/uart_cmd_rcv.sv
// uart_cmd_rcv: 8N1 UART receiver with rdy/clr_rdy handshake and G/S power-up authorization.
// Define UART_CMD_MAJORITY_EN for 2-of-3 majority sampling around each sample point.
module uart_cmd_rcv
  import uart_cmd_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       clr_rdy,
  input  logic       rider_off,
  output logic       rdy,
  output logic [7:0] rx_data,
  output logic       frm_err,
  output logic       pwr_up
);
  localparam logic [11:0] FULL = 12'(BAUD_DIV);
  localparam logic [11:0] HALF = 12'(BAUD_DIV / 2);
  rx_state_t state_q, state_d;
  logic rx_meta_q, rx_s_q;
  logic [11:0] baud_cnt_q, baud_cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d, rx_data_q, rx_data_d;
  logic rdy_q, rdy_d, rx_vld_q, rx_vld_d, frm_err_q, frm_err_d;
  logic expire, smp;
  assign expire = baud_cnt_q == 12'd1;
`ifdef UART_CMD_MAJORITY_EN
  logic [1:0] hist_q;
  always_ff @(posedge clk) begin
    if (rst) hist_q <= 2'b11;
    else hist_q <= {hist_q[0], rx_s_q};
  end
  assign smp = (rx_s_q & hist_q[0]) | (rx_s_q & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
  assign smp = rx_s_q;
`endif
  always_comb begin
    state_d = state_q;
    baud_cnt_d = (state_q == RX_IDLE || state_q == RX_BREAK) ? baud_cnt_q : baud_cnt_q - 12'd1;
    bit_cnt_d = bit_cnt_q;
    shift_d = shift_q;
    rx_data_d = rx_data_q;
    rdy_d = clr_rdy ? 1'b0 : rdy_q;
    rx_vld_d = 1'b0;
    frm_err_d = 1'b0;
    unique case (state_q)
      RX_IDLE: if (!rx_s_q) begin
        baud_cnt_d = HALF;
        rdy_d = 1'b0;
        state_d = RX_START;
      end
      RX_START: if (expire) begin
        state_d = smp ? RX_IDLE : RX_DATA;
        baud_cnt_d = FULL;
        bit_cnt_d = 3'd0;
      end
      RX_DATA: if (expire) begin
        shift_d = {smp, shift_q[7:1]};
        baud_cnt_d = FULL;
        bit_cnt_d = bit_cnt_q + 3'd1;
        state_d = bit_cnt_q == 3'd7 ? RX_STOP : RX_DATA;
      end
      RX_STOP: if (expire) begin
        state_d = smp ? RX_IDLE : RX_BREAK;
        rx_data_d = smp ? shift_q : rx_data_q;
        rdy_d = smp | rdy_d;
        rx_vld_d = smp;
        frm_err_d = !smp;
      end
      RX_BREAK: state_d = rx_s_q ? RX_IDLE : RX_BREAK;
      default: state_d = RX_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q <= 1'b1;
      state_q <= RX_IDLE;
      baud_cnt_q <= 12'd0;
      bit_cnt_q <= 3'd0;
      shift_q <= 8'h00;
      rx_data_q <= 8'h00;
      rdy_q <= 1'b0;
      rx_vld_q <= 1'b0;
      frm_err_q <= 1'b0;
    end else begin
      rx_meta_q <= RX;
      rx_s_q <= rx_meta_q;
      state_q <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q <= shift_d;
      rx_data_q <= rx_data_d;
      rdy_q <= rdy_d;
      rx_vld_q <= rx_vld_d;
      frm_err_q <= frm_err_d;
    end
  end
  assign rdy = rdy_q;
  assign rx_data = rx_data_q;
  assign frm_err = frm_err_q;
  uart_cmd_auth u_auth (
    .clk      (clk),
    .rst      (rst),
    .rx_vld   (rx_vld_q),
    .rx_data  (rx_data_q),
    .rider_off(rider_off),
    .pwr_up   (pwr_up)
  );
endmodule

// File: tb/tb_uart_cmd_rcv.sv
// tb_uart_cmd_rcv: directed and random frames against a protocol-level model of the receiver and G/S authorizer
module tb_uart_cmd_rcv;
  localparam int BD = 32;
  logic clk = 1'b0, rst = 1'b1, RX = 1'b1, clr_rdy = 1'b0, rider_off = 1'b0;
  logic rdy, frm_err, pwr_up;
  logic [7:0] rx_data;
  int n_chk = 0, n_fail = 0, ferr_seen = 0, ferr_exp = 0;
  int m_st = 0;
  logic [7:0] m_data = 8'h00;
  logic m_rdy = 1'b0, m_rider = 1'b0;
  uart_cmd_rcv #(.BAUD_DIV(BD)) dut (
    .clk(clk), .rst(rst), .RX(RX), .clr_rdy(clr_rdy), .rider_off(rider_off),
    .rdy(rdy), .rx_data(rx_data), .frm_err(frm_err), .pwr_up(pwr_up)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (frm_err) ferr_seen++;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic m_byte(input logic [7:0] b);
    m_data = b;
    m_rdy = 1'b1;
    if (m_st == 0) m_st = (b == "G") ? 1 : 0;
    else if (m_st == 1) m_st = (b == "S") ? (m_rider ? 0 : 2) : 1;
    else m_st = (b == "G") ? 1 : (m_rider ? 0 : 2);
  endtask
  task automatic idle_rx(input int n);
    RX = 1'b1;
    repeat (n) @(negedge clk);
  endtask
  task automatic set_rider(input logic v);
    rider_off = v;
    m_rider = v;
    if (v && m_st == 2) m_st = 0;
    @(negedge clk);
    check("pwr_rider", pwr_up, m_st != 0);
  endtask
  task automatic pulse_clr();
    clr_rdy = 1'b1;
    @(negedge clk);
    clr_rdy = 1'b0;
    m_rdy = 1'b0;
    check("rdy_clr", rdy, 0);
  endtask
  task automatic send_frame(input logic [7:0] b, input logic stop_ok);
    int n;
    logic got;
    RX = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (BD) @(negedge clk);
    end
    RX = stop_ok;
    m_rdy = 1'b0;
    n = 0;
    got = 1'b0;
    while (n < 2 * BD && !got) begin
      @(negedge clk);
      n++;
      got = stop_ok ? rdy : frm_err;
    end
    check(stop_ok ? "rdy_event" : "ferr_event", got, 1);
    if (got && stop_ok) begin
      check("rx_data", rx_data, b);
      check("pwr_at_vld", pwr_up, m_st != 0);
      m_byte(b);
      @(negedge clk);
      n++;
      check("pwr_after_vld", pwr_up, m_st != 0);
      check("rdy_hold", rdy, 1);
    end else if (got) begin
      ferr_exp++;
      check("rdy_ferr", rdy, 0);
      check("data_ferr", rx_data, m_data);
      @(negedge clk);
      n++;
      check("ferr_pulse", frm_err, 0);
      check("pwr_ferr", pwr_up, m_st != 0);
    end
    if (n < BD) repeat (BD - n) @(negedge clk);
  endtask
  initial begin
    logic [7:0] b;
    int sel;
    repeat (3) @(negedge clk);
    check("rst_rdy", rdy, 0);
    check("rst_data", rx_data, 8'h00);
    check("rst_ferr", frm_err, 0);
    check("rst_pwr", pwr_up, 0);
    rst = 1'b0;
    idle_rx(BD);
    send_frame(8'hA5, 1'b1);
    check("no_ferr_a5", ferr_seen, 0);
    pulse_clr();
    send_frame(8'h47, 1'b1);
    send_frame(8'h53, 1'b1);
    check("pwr_pend", pwr_up, 1);
    set_rider(1'b1);
    set_rider(1'b0);
    send_frame(8'h53, 1'b1);
    send_frame(8'h47, 1'b1);
    send_frame(8'h12, 1'b1);
    send_frame(8'h99, 1'b0);
    repeat (12 * BD) @(negedge clk);
    check("break_rdy", rdy, 0);
    check("break_ferr_cnt", ferr_seen, 1);
    idle_rx(BD);
    RX = 1'b0;
    repeat (BD * 3 / 10) @(negedge clk);
    m_rdy = 1'b0;
    idle_rx(2 * BD);
    check("glitch_rdy", rdy, 0);
    send_frame(8'h3C, 1'b1);
    idle_rx(BD);
    send_frame(8'h47, 1'b1);
    RX = 1'b0;
    repeat (3 * BD) @(negedge clk);
    RX = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_rdy", rdy, 0);
    check("mid_rst_data", rx_data, 8'h00);
    check("mid_rst_ferr", frm_err, 0);
    check("mid_rst_pwr", pwr_up, 0);
    m_st = 0;
    m_rdy = 1'b0;
    m_data = 8'h00;
    idle_rx(2 * BD);
    send_frame(8'h47, 1'b1);
    for (int k = 0; k < 40; k++) begin
      sel = $urandom_range(0, 3);
      b = sel == 0 ? 8'h47 : sel == 1 ? 8'h53 : 8'($urandom);
      if ($urandom_range(0, 3) == 0) set_rider(1'($urandom));
      if ($urandom_range(0, 7) == 0) begin
        send_frame(b, 1'b0);
        idle_rx(BD);
      end else begin
        send_frame(b, 1'b1);
        if ($urandom_range(0, 1) == 1) pulse_clr();
        idle_rx($urandom_range(0, BD));
      end
      check("rdy_end", rdy, m_rdy);
      check("pwr_end", pwr_up, m_st != 0);
    end
    check("ferr_total", ferr_seen, ferr_exp);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
